// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between instruction fetch (ibus) and load/store
//   (dbus). It registers one transaction at a time and holds it on the memory
//   port until mem_ready. It then returns the read data with a one-cycle ack.
//   It also produces the stall that freezes the core control FSM.
//
// Optional feature (compile-time macro BUS_TIMEOUT_EN):
//   When defined, a transaction that waits TIMEOUT_CYC cycles without
//   mem_ready is aborted. The abort pulses ack and bus_err together and
//   returns 32'hDEAD_BEEF (replicated) as read data.
//   When undefined, BUSY waits indefinitely and bus_err is tied low.
//
// State  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// BUSY_I | fetch on the memory port, waiting for mem_ready
// BUSY_D | load/store on the memory port, waiting for mem_ready
// ACK    | ack pulse cycle; no grant is made here
//
// Parameters: ADDR_W, DATA_W, ARB_MODE (0 fixed dbus priority, 1 round-robin),
//             TIMEOUT_CYC (2..255, only used with BUS_TIMEOUT_EN)
// Ports:
//   clk, rst                        clock, async active-high reset
//   ibus_req/addr/rdata/ack         fetch requester
//   dbus_req/we/addr/wdata/be/rdata/ack  load/store requester
//   mem_req/we/addr/wdata/be        registered memory request
//   mem_rdata, mem_ready            memory response
//   stall                           some requester is still waiting
//   bus_err                         timeout abort pulse, coincident with ack
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus_req,
  input  logic [ADDR_W-1:0]   ibus_addr,
  output logic [DATA_W-1:0]   ibus_rdata,
  output logic                ibus_ack,
  input  logic                dbus_req,
  input  logic                dbus_we,
  input  logic [ADDR_W-1:0]   dbus_addr,
  input  logic [DATA_W-1:0]   dbus_wdata,
  input  logic [DATA_W/8-1:0] dbus_be,
  output logic [DATA_W-1:0]   dbus_rdata,
  output logic                dbus_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                stall,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_t;

  state_t state;
  logic   last_grant;
  logic   grant_d;

  // On a conflict, round-robin hands the port to whichever side did not get
  // the previous grant.
  always_comb begin
    grant_d = dbus_req;
    if (ibus_req && dbus_req) begin
      if (ARB_MODE == 0) grant_d = 1'b1;
      else               grant_d = (last_grant == GNT_I);
    end
  end

  // A side stops stalling in its ack cycle even if req is still high.
  assign stall = (ibus_req & ~ibus_ack) | (dbus_req & ~dbus_ack);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LAST;
  assign bus_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      ibus_ack   <= 1'b0;
      dbus_ack   <= 1'b0;
      ibus_rdata <= '0;
      dbus_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
      bus_err    <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      ibus_ack <= 1'b0;
      dbus_ack <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ibus_req || dbus_req) begin
            last_grant <= grant_d ? GNT_D : GNT_I;
            mem_req    <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
            if (grant_d) begin
              mem_we    <= dbus_we;
              mem_addr  <= dbus_addr;
              mem_wdata <= dbus_wdata;
              mem_be    <= dbus_we ? dbus_be : {BE_W{1'b1}};
              state     <= BUSY_D;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= ibus_addr;
              mem_wdata <= '0;
              mem_be    <= {BE_W{1'b1}};
              state     <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ACK;
            if (state == BUSY_I) begin
              ibus_rdata <= mem_rdata;
              ibus_ack   <= 1'b1;
            end else begin
              // A store leaves the previous load data in place.
              if (!mem_we) dbus_rdata <= mem_rdata;
              dbus_ack <= 1'b1;
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            state   <= ACK;
            if (state == BUSY_I) begin
              ibus_rdata <= {(DATA_W/32){32'hDEAD_BEEF}};
              ibus_ack   <= 1'b1;
            end else begin
              dbus_rdata <= {(DATA_W/32){32'hDEAD_BEEF}};
              dbus_ack   <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Two arbiter instances: unit 0 uses ARB_MODE=0 and unit 1 uses ARB_MODE=1.
//   Each unit has its own bus signals and its own memory model.
//   Stimulus pushes the expected memory transactions and acks into queues.
//   A negedge monitor pops these queues and compares them against the DUT
//   outputs. The timeout scenario follows the BUS_TIMEOUT_EN macro.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack;
  logic [1:0]       mem_req, mem_we, mem_ready, stall, bus_err;
  logic [1:0][31:0] ibus_addr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  dbus_be, mem_be;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arbiter #(.ARB_MODE(g)) dut (
      .clk(clk), .rst(rst),
      .ibus_req(ibus_req[g]), .ibus_addr(ibus_addr[g]),
      .ibus_rdata(ibus_rdata[g]), .ibus_ack(ibus_ack[g]),
      .dbus_req(dbus_req[g]), .dbus_we(dbus_we[g]), .dbus_addr(dbus_addr[g]),
      .dbus_wdata(dbus_wdata[g]), .dbus_be(dbus_be[g]),
      .dbus_rdata(dbus_rdata[g]), .dbus_ack(dbus_ack[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]),
      .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g]),
      .stall(stall[g]), .bus_err(bus_err[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;   // expected cycles of mem_req high; 0 = not checked
  } mtx_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  mtx_t mem_q [2][$];
  ack_t ack_q [4][$];   // index unit*2 + side (0 = ibus, 1 = dbus)

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Memory model: ready after lat[u] wait cycles, or never while never_rdy[u].
  logic [31:0] mem_img [logic [31:0]];
  int          lat       [2];
  bit          never_rdy [2];
  int          wcnt      [2];

  always begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (rst || !mem_req[u]) begin
        mem_ready[u] = 1'b0;
        wcnt[u]      = 0;
      end else if (!never_rdy[u] && wcnt[u] == lat[u]) begin
        mem_ready[u] = 1'b1;
        mem_rdata[u] = mem_img.exists(mem_addr[u]) ? mem_img[mem_addr[u]] : 32'h0;
        wcnt[u]++;
      end else begin
        mem_ready[u] = 1'b0;
        wcnt[u]++;
      end
    end
  end

  // Monitor
  logic [1:0] prev_req = 2'b00;
  mtx_t       cur [2];
  int         run [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      for (int s = 0; s < 2; s++) begin
        logic a;
        ack_t e;
        a = (s == 1) ? dbus_ack[u] : ibus_ack[u];
        if (a) begin
          chk("ack_expected", 32'(ack_q[u*2+s].size() != 0), 32'd1);
          if (ack_q[u*2+s].size() != 0) begin
            e = ack_q[u*2+s].pop_front();
            chk("ack_rdata", (s == 1) ? dbus_rdata[u] : ibus_rdata[u], e.rdata);
            chk("ack_bus_err", 32'(bus_err[u]), 32'(e.err));
          end
        end
      end
      if (bus_err[u]) chk("bus_err_with_ack", 32'(ibus_ack[u] | dbus_ack[u]), 32'd1);
      if (mem_req[u] && !prev_req[u]) begin
        chk("mem_txn_expected", 32'(mem_q[u].size() != 0), 32'd1);
        if (mem_q[u].size() != 0) cur[u] = mem_q[u].pop_front();
        else                      cur[u].len = 0;
        run[u] = 1;
        chk("mem_addr", mem_addr[u], cur[u].addr);
        chk("mem_we", 32'(mem_we[u]), 32'(cur[u].we));
        chk("mem_be", 32'(mem_be[u]), 32'(cur[u].be));
        if (cur[u].we) chk("mem_wdata", mem_wdata[u], cur[u].wdata);
      end else if (mem_req[u] && prev_req[u]) begin
        run[u]++;
        chk("mem_addr_stable", mem_addr[u], cur[u].addr);
        chk("mem_we_stable", 32'(mem_we[u]), 32'(cur[u].we));
        chk("mem_be_stable", 32'(mem_be[u]), 32'(cur[u].be));
        if (cur[u].we) chk("mem_wdata_stable", mem_wdata[u], cur[u].wdata);
      end else if (!mem_req[u] && prev_req[u] && cur[u].len != 0) begin
        chk("mem_req_len", 32'(run[u]), 32'(cur[u].len));
      end
      prev_req[u] = mem_req[u];
    end
  end

  function automatic void exp_mem(int u, logic [31:0] a, logic we,
                                  logic [31:0] wd, logic [3:0] be, int len);
    mtx_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.be = be; t.len = len;
    mem_q[u].push_back(t);
  endfunction

  function automatic void exp_ack(int u, int s, logic [31:0] rd, logic err);
    ack_t t;
    t.rdata = rd; t.err = err;
    ack_q[u*2+s].push_back(t);
  endfunction

  // Raise a request and hold it until ack. The request drops one cycle after
  // the ack. drop_after > 0 drops it early, at that negedge. n returns the
  // number of clock edges from the request to the ack.
  task automatic txn(input int u, input bit d, input logic [31:0] addr,
                     input bit we, input logic [31:0] wd, input logic [3:0] be,
                     input int drop_after, output int n);
    bit got = 1'b0;
    n = 0;
    if (d) begin
      dbus_req[u] = 1'b1; dbus_we[u] = we; dbus_addr[u] = addr;
      dbus_wdata[u] = wd; dbus_be[u] = be;
    end else begin
      ibus_req[u] = 1'b1; ibus_addr[u] = addr;
    end
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (drop_after > 0 && n == drop_after) begin
        if (d) dbus_req[u] = 1'b0; else ibus_req[u] = 1'b0;
      end
      got = d ? dbus_ack[u] : ibus_ack[u];
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    n = n - 1;
    @(posedge clk);
    #1;
    if (d) dbus_req[u] = 1'b0; else ibus_req[u] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    ibus_req = '0; dbus_req = '0; dbus_we = '0;
    ibus_addr = '0; dbus_addr = '0; dbus_wdata = '0; dbus_be = '0;
    mem_ready = '0; mem_rdata = '0;
    for (int u = 0; u < 2; u++) begin lat[u] = 0; never_rdy[u] = 1'b0; end
    mem_img[32'h100]  = 32'h0000_0013;
    mem_img[32'h104]  = 32'h0050_0093;
    mem_img[32'h200]  = 32'h1111_1111;
    mem_img[32'h204]  = 32'h2222_2222;
    mem_img[32'h3000] = 32'hAAAA_0001;
    mem_img[32'h3004] = 32'hAAAA_0002;
    mem_img[32'h3008] = 32'h0BAD_F00D;

    // Reset state
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_mem_req", 32'(mem_req[u]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[u]), 32'd0);
      chk("rst_mem_addr", mem_addr[u], 32'd0);
      chk("rst_acks", 32'({ibus_ack[u], dbus_ack[u], bus_err[u]}), 32'd0);
      chk("rst_rdata", ibus_rdata[u] | dbus_rdata[u], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch, minimum turnaround
    exp_mem(0, 32'h100, 1'b0, 32'h0, 4'hF, 1);
    exp_ack(0, 0, 32'h0000_0013, 1'b0);
    txn(0, 1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 0, n);
    chk("fetch_latency", 32'(n), 32'd2);
    @(negedge clk);
    chk("stall_after_ack", 32'(stall[0]), 32'd0);
    @(posedge clk); #1;

    // Conflicts on both units. Unit 0 has fixed dbus priority; unit 1 is
    // round-robin and alternates D, I, D over three conflicts.
    exp_mem(0, 32'h3000, 1'b0, 32'h0, 4'hF, 1);
    exp_mem(0, 32'h3004, 1'b0, 32'h0, 4'hF, 1);
    exp_mem(0, 32'h200,  1'b0, 32'h0, 4'hF, 1);
    exp_mem(0, 32'h204,  1'b0, 32'h0, 4'hF, 1);
    exp_mem(1, 32'h3000, 1'b0, 32'h0, 4'hF, 1);
    exp_mem(1, 32'h200,  1'b0, 32'h0, 4'hF, 1);
    exp_mem(1, 32'h3004, 1'b0, 32'h0, 4'hF, 1);
    exp_mem(1, 32'h204,  1'b0, 32'h0, 4'hF, 1);
    for (int u = 0; u < 2; u++) begin
      exp_ack(u, 0, 32'h1111_1111, 1'b0);
      exp_ack(u, 0, 32'h2222_2222, 1'b0);
      exp_ack(u, 1, 32'hAAAA_0001, 1'b0);
      exp_ack(u, 1, 32'hAAAA_0002, 1'b0);
    end
    fork
      begin int k; txn(0, 1'b0, 32'h200, 1'b0, 0, 4'h0, 0, k); txn(0, 1'b0, 32'h204, 1'b0, 0, 4'h0, 0, k); end
      begin int k; txn(0, 1'b1, 32'h3000, 1'b0, 32'h77, 4'h0, 0, k); txn(0, 1'b1, 32'h3004, 1'b0, 32'h77, 4'h0, 0, k); end
      begin int k; txn(1, 1'b0, 32'h200, 1'b0, 0, 4'h0, 0, k); txn(1, 1'b0, 32'h204, 1'b0, 0, 4'h0, 0, k); end
      begin int k; txn(1, 1'b1, 32'h3000, 1'b0, 32'h77, 4'h0, 0, k); txn(1, 1'b1, 32'h3004, 1'b0, 32'h77, 4'h0, 0, k); end
    join
    chk("conflict_u0_drained", 32'(mem_q[0].size()), 32'd0);
    chk("conflict_u1_drained", 32'(mem_q[1].size()), 32'd0);
    @(posedge clk); #1;

    // Store with three wait cycles; dbus_rdata keeps the last load data.
    lat[0] = 3;
    exp_mem(0, 32'h2000, 1'b1, 32'hCAFE_F00D, 4'b0011, 4);
    exp_ack(0, 1, 32'hAAAA_0002, 1'b0);
    fork
      txn(0, 1'b1, 32'h2000, 1'b1, 32'hCAFE_F00D, 4'b0011, 0, n);
      begin repeat (2) @(negedge clk); chk("stall_while_busy", 32'(stall[0]), 32'd1); end
    join
    chk("store_latency", 32'(n), 32'd5);
    @(posedge clk); #1;

    // Load whose requester drops req early; it still completes once.
    exp_mem(0, 32'h3008, 1'b0, 32'h0, 4'hF, 4);
    exp_ack(0, 1, 32'h0BAD_F00D, 1'b0);
    txn(0, 1'b1, 32'h3008, 1'b0, 32'h0, 4'h0, 2, n);
    repeat (4) @(negedge clk);
    chk("drop_no_retry", 32'(mem_q[0].size()), 32'd0);
    lat[0] = 0;
    @(posedge clk); #1;

    // Reset in the middle of BUSY_D
    never_rdy[0] = 1'b1;
    exp_mem(0, 32'h4000, 1'b1, 32'h1234_5678, 4'hF, 0);
    dbus_req[0] = 1'b1; dbus_we[0] = 1'b1; dbus_addr[0] = 32'h4000;
    dbus_wdata[0] = 32'h1234_5678; dbus_be[0] = 4'hF;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(mem_req[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(mem_req[0]), 32'd0);
    chk("rst_no_ack", 32'(dbus_ack[0]), 32'd0);
    dbus_req[0] = 1'b0; dbus_we[0] = 1'b0;
    never_rdy[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dbus_rdata", dbus_rdata[0], 32'd0);
    @(posedge clk); #1;
    exp_mem(0, 32'h104, 1'b0, 32'h0, 4'hF, 1);
    exp_ack(0, 0, 32'h0050_0093, 1'b0);
    txn(0, 1'b0, 32'h104, 1'b0, 32'h0, 4'h0, 0, n);
    chk("post_rst_fetch_latency", 32'(n), 32'd2);
    @(posedge clk); #1;

    // Memory never ready
    never_rdy[0] = 1'b1;
`ifdef BUS_TIMEOUT_EN
    exp_mem(0, 32'h108, 1'b0, 32'h0, 4'hF, 16);
    exp_ack(0, 0, 32'hDEAD_BEEF, 1'b1);
    txn(0, 1'b0, 32'h108, 1'b0, 32'h0, 4'h0, 0, n);
    chk("timeout_latency", 32'(n), 32'd17);
`else
    exp_mem(0, 32'h108, 1'b0, 32'h0, 4'hF, 0);
    ibus_req[0] = 1'b1; ibus_addr[0] = 32'h108;
    repeat (100) @(negedge clk);
    chk("no_timeout_busy", 32'(mem_req[0]), 32'd1);
    chk("no_timeout_bus_err", 32'(bus_err[0]), 32'd0);
    chk("no_timeout_ack", 32'(ibus_ack[0]), 32'd0);
    #2 rst = 1'b1;
    ibus_req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    never_rdy[0] = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) chk("ack_queue_empty", 32'(ack_q[i].size()), 32'd0);
    chk("mem_queue_empty", 32'(mem_q[0].size() + mem_q[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
